// File: rtl/yolo_ctrl_pkg.sv
// Shared types and defaults for the frame sequencing controller.
package yolo_ctrl_pkg;

  localparam int unsigned CNT_W         = 18;
  localparam int unsigned DEF_IN_COUNT  = 173056;  // 416 x 416
  localparam int unsigned DEF_OUT_COUNT = 169;     // 13 x 13
  localparam int unsigned DEF_TIMEOUT   = 65535;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_counter.sv
// Clear/enable up-counter with a terminal-count flag (count == MAX).
module seq_counter #(
  parameter int unsigned W   = 18,
  parameter int unsigned MAX = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  // Clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(MAX));

endmodule

// File: rtl/core_seq_ctrl.sv
// Frame sequencer: streams IN_COUNT vectors into the core, then waits for
// OUT_COUNT results under a drain watchdog.
module core_seq_ctrl
  import yolo_ctrl_pkg::*;
#(
  parameter int unsigned IN_COUNT  = DEF_IN_COUNT,
  parameter int unsigned OUT_COUNT = DEF_OUT_COUNT,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned DATA_W    = 96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] core_data,
  output logic              core_valid_in,
  input  logic              core_full,
  input  logic              core_empty,
  input  logic              core_valid_out,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_spurious,
  output logic [CNT_W-1:0]  in_cnt,
  output logic [CNT_W-1:0]  out_cnt
);

  state_t           state;
  logic             in_tc;
  logic             out_tc;
  logic             wd_tc;
  logic [CNT_W-1:0] wd_cnt;
  logic             xfer;
  logic             go;
  logic             in_last;
  logic             drain_fin;
  logic             wd_expire;

  // in_cnt never exceeds IN_COUNT, so !in_tc is equivalent to in_cnt < IN_COUNT.
  assign src_ready = (state == LOAD) && !core_full && !in_tc;
  assign xfer      = src_valid && src_ready && !abort;
  assign go        = (state == IDLE) && start && !abort;
  assign in_last   = (in_cnt == CNT_W'(IN_COUNT - 1));
  assign drain_fin = (state == DRAIN) && out_tc && core_empty;
  assign wd_expire = (state == DRAIN) && !core_valid_out && !drain_fin &&
                     (wd_cnt == CNT_W'(TIMEOUT - 1));

  seq_counter #(.W(CNT_W), .MAX(IN_COUNT)) u_in_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .en    (xfer),
    .count (in_cnt),
    .tc    (in_tc)
  );

  seq_counter #(.W(CNT_W), .MAX(OUT_COUNT)) u_out_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .en    (((state == LOAD) || (state == DRAIN)) && core_valid_out && !out_tc && !abort),
    .count (out_cnt),
    .tc    (out_tc)
  );

  // Watchdog reloads on each core output and saturates at TIMEOUT.
  seq_counter #(.W(CNT_W), .MAX(TIMEOUT)) u_wd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go || ((state == DRAIN) && core_valid_out && !abort)),
    .en    ((state == DRAIN) && !core_valid_out && !wd_tc && !abort),
    .count (wd_cnt),
    .tc    (wd_tc)
  );

  // Sequencing FSM with registered outputs; abort overrides every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      core_data     <= '0;
      core_valid_in <= 1'b0;
      err_timeout   <= 1'b0;
      err_spurious  <= 1'b0;
    end else begin
      core_valid_in <= 1'b0;
      done          <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        if ((state == IDLE) && core_valid_out) err_spurious <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= LOAD;
              busy         <= 1'b1;
              err_timeout  <= 1'b0;
              err_spurious <= 1'b0;
            end else if (core_valid_out) begin
              err_spurious <= 1'b1;
            end
          end
          LOAD: begin
            if (xfer) begin
              core_data     <= src_data;
              core_valid_in <= 1'b1;
              if (in_last) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (drain_fin) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (wd_expire) begin
              state       <= DONE;
              done        <= 1'b1;
              err_timeout <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
